// File: rtl/write_bpm_test_link.sv
// write_bpm_test_link
//   Test-pattern source for the BPM Aurora test link. Each FA strobe starts a
//   burst of BPM_COUNT synthetic BPM position packets (4 words each) on an
//   AXI4-Stream TX interface. Packet contents depend only on the frame counter
//   and the BPM index, so the receive path can be checked without real BPMs.
//
//   Ports:
//     auroraUserClk                 Aurora user clock, rising edge
//     auroraReset                   asynchronous active-high reset
//     auroraFAstrobe                single-cycle FA strobe, starts a burst in IDLE
//     BPM_TEST_AXI_STREAM_TX_tdata  32-bit stream data (registered)
//     BPM_TEST_AXI_STREAM_TX_tvalid stream valid (registered)
//     BPM_TEST_AXI_STREAM_TX_tlast  last word of each packet (registered)
//     BPM_TEST_AXI_STREAM_TX_tready sink ready
//
//   Packet p of a burst with frame value F:
//     W0 {MAGIC, CELL_INDEX, p}   W1 F+p   W2 -(F+p)   W3 32'h0100_0000+p (tlast)
module write_bpm_test_link #(
  parameter int unsigned BPM_COUNT  = 4,
  parameter logic [7:0]  CELL_INDEX = 8'h00,
  parameter logic [15:0] MAGIC      = 16'hA5BE
) (
  input  logic        auroraUserClk,
  input  logic        auroraReset,
  input  logic        auroraFAstrobe,
  output logic [31:0] BPM_TEST_AXI_STREAM_TX_tdata,
  output logic        BPM_TEST_AXI_STREAM_TX_tvalid,
  output logic        BPM_TEST_AXI_STREAM_TX_tlast,
  input  logic        BPM_TEST_AXI_STREAM_TX_tready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [7:0] LAST_BPM = 8'(BPM_COUNT - 1);

  logic [0:0]  state;
  logic [31:0] frame_count;
  logic [7:0]  bpm_index;
  logic [1:0]  word_index;

  logic        accepted;
  logic        last_word;
  logic [7:0]  next_bpm;
  logic [1:0]  next_word;

  function automatic logic [31:0] word_at(input logic [31:0] f,
                                          input logic [7:0]  p,
                                          input logic [1:0]  w);
    logic [31:0] x;
    x = f + {24'd0, p};
    case (w)
      2'd0:    return {MAGIC, CELL_INDEX, p};
      2'd1:    return x;
      2'd2:    return 32'd0 - x;
      default: return 32'h0100_0000 + {24'd0, p};
    endcase
  endfunction

  always_comb begin
    accepted  = BPM_TEST_AXI_STREAM_TX_tvalid && BPM_TEST_AXI_STREAM_TX_tready;
    last_word = (bpm_index == LAST_BPM) && (word_index == 2'd3);
    next_word = word_index + 2'd1;
    next_bpm  = (word_index == 2'd3) ? bpm_index + 8'd1 : bpm_index;
  end

  // Output registers are loaded with the word that will be presented next, so
  // tdata/tlast only change on an accepted transfer and hold while stalled.
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      state                         <= ST_IDLE;
      frame_count                   <= '0;
      bpm_index                     <= '0;
      word_index                    <= '0;
      BPM_TEST_AXI_STREAM_TX_tdata  <= '0;
      BPM_TEST_AXI_STREAM_TX_tvalid <= 1'b0;
      BPM_TEST_AXI_STREAM_TX_tlast  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (auroraFAstrobe) begin
            frame_count                   <= frame_count + 32'd1;
            bpm_index                     <= '0;
            word_index                    <= '0;
            BPM_TEST_AXI_STREAM_TX_tdata  <= word_at(frame_count + 32'd1, 8'd0, 2'd0);
            BPM_TEST_AXI_STREAM_TX_tvalid <= 1'b1;
            BPM_TEST_AXI_STREAM_TX_tlast  <= 1'b0;
            state                         <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Strobes are deliberately ignored here: no counter change, no queued burst.
          if (accepted) begin
            if (last_word) begin
              BPM_TEST_AXI_STREAM_TX_tvalid <= 1'b0;
              BPM_TEST_AXI_STREAM_TX_tlast  <= 1'b0;
              state                         <= ST_IDLE;
            end else begin
              bpm_index                    <= next_bpm;
              word_index                   <= next_word;
              BPM_TEST_AXI_STREAM_TX_tdata <= word_at(frame_count, next_bpm, next_word);
              BPM_TEST_AXI_STREAM_TX_tlast <= (next_word == 2'd3);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_bpm_test_link.sv
// tb_write_bpm_test_link
//   Directed bench for write_bpm_test_link (BPM_COUNT=4, CELL_INDEX=0,
//   MAGIC=16'hA5BE). Inputs are driven on the falling edge, outputs are
//   sampled on the falling edge, transfers happen on the rising edge.
module tb_write_bpm_test_link;

  localparam int NBPM = 4;

  logic        clk;
  logic        rst;
  logic        strobe;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  int vectors;
  int miscompares;

  write_bpm_test_link #(
    .BPM_COUNT (NBPM),
    .CELL_INDEX(8'h00),
    .MAGIC     (16'hA5BE)
  ) dut (
    .auroraUserClk                (clk),
    .auroraReset                  (rst),
    .auroraFAstrobe               (strobe),
    .BPM_TEST_AXI_STREAM_TX_tdata (tdata),
    .BPM_TEST_AXI_STREAM_TX_tvalid(tvalid),
    .BPM_TEST_AXI_STREAM_TX_tlast (tlast),
    .BPM_TEST_AXI_STREAM_TX_tready(tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle_no;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  function automatic logic [31:0] model(input logic [31:0] f, input logic [7:0] p,
                                        input logic [1:0] w);
    logic [31:0] x;
    x = f + 32'(p);
    case (w)
      2'd0:    return {16'hA5BE, 8'h00, p};
      2'd1:    return x;
      2'd2:    return ~x + 32'd1;
      default: return 32'h0100_0000 | 32'(p);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge after the strobe was captured. Walks all
  // 4*NBPM words; ghost_at pulses a strobe on that burst cycle (must be ignored).
  task automatic run_burst(input logic [31:0] f, input bit rnd, input int ghost_at);
    int          cyc;
    int          stalls;
    logic [31:0] exp_d;
    logic [7:0]  p;
    logic [1:0]  w;
    cyc   = 0;
    exp_d = '0;
    for (int k = 0; k < 4 * NBPM; k++) begin
      p      = 8'(k / 4);
      w      = 2'(k % 4);
      exp_d  = model(f, p, w);
      stalls = 0;
      forever begin
        strobe = (cyc == ghost_at);
        tready = (rnd && stalls < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
        check("burst_tvalid", 32'(tvalid), 32'd1);
        check("burst_tdata",  tdata, exp_d);
        check("burst_tlast",  32'(tlast), 32'(w == 2'd3));
        cyc++;
        if (tready) begin
          @(posedge clk);
          @(negedge clk);
          break;
        end
        stalls++;
        @(negedge clk);
      end
    end
    strobe = 1'b0;
    check("end_tvalid", 32'(tvalid), 32'd0);
    check("end_tlast",  32'(tlast),  32'd0);
    check("end_tdata",  tdata, exp_d);
  endtask

  task automatic fire_strobe();
    check("idle_tvalid", 32'(tvalid), 32'd0);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  initial begin
    int start_cyc;
    vectors     = 0;
    miscompares = 0;
    cycle_no    = 0;
    rst         = 1'b1;
    strobe      = 1'b0;
    tready      = 1'b1;

    // 1: reset held while strobes toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      strobe = ~strobe;
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tlast",  32'(tlast),  32'd0);
      check("rst_tdata",  tdata, 32'd0);
    end
    strobe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 2: tready constant, first burst F=1, hand-checked first packet
    fire_strobe();
    check("t2_w0_hand", tdata, 32'hA5BE_0000);
    @(posedge clk); @(negedge clk);
    check("t2_w1_hand", tdata, 32'h0000_0001);
    @(posedge clk); @(negedge clk);
    check("t2_w2_hand", tdata, 32'hFFFF_FFFF);
    @(posedge clk); @(negedge clk);
    check("t2_w3_hand", tdata, 32'h0100_0000);
    check("t2_w3_tlast", 32'(tlast), 32'd1);
    @(posedge clk); @(negedge clk);
    check("t2_p1_hdr", tdata, 32'hA5BE_0001);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    // rest of burst 1 is left to drain; restart it cleanly with the next test
    while (tvalid) @(negedge clk);
    @(negedge clk);

    // 4: strobe mid-burst ignored (F=2), then strobe on final-accept cycle (F=3)
    fire_strobe();
    run_burst(32'd2, 1'b0, 3);
    @(negedge clk);
    fire_strobe();
    run_burst(32'd3, 1'b0, 4 * NBPM - 1);
    @(negedge clk);
    fire_strobe();
    run_burst(32'd4, 1'b0, -1);

    // 3: random backpressure, strobe every 201 cycles
    for (int n = 5; n < 8; n++) begin
      @(negedge clk);
      start_cyc = cycle_no;
      fire_strobe();
      run_burst(32'(n), 1'b1, -1);
      tready = 1'b1;
      while (cycle_no - start_cyc < 201) @(negedge clk);
    end

    // 5: reset mid-burst drops tvalid immediately, restart with F=1
    @(negedge clk);
    fire_strobe();
    repeat (6) @(negedge clk);
    check("t5_mid_tvalid", 32'(tvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_tvalid", 32'(tvalid), 32'd0);
    check("t5_rst_tdata",  tdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fire_strobe();
    run_burst(32'd1, 1'b0, -1);

    // 6: frame counter wrap 0xFFFFFFFF -> 0
    @(negedge clk);
    force dut.frame_count = 32'hFFFF_FFFF;
    #1 release dut.frame_count;
    @(negedge clk);
    fire_strobe();
    check("t6_hdr", tdata, 32'hA5BE_0000);
    run_burst(32'd0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: observed no finish, expected finish before 400000");
    $fatal(1, "timeout");
  end

endmodule
